// File: rtl/data_mem_wbuf.sv
// Data memory with a small store FIFO in front of a single-port word RAM.
// Stores retire in load-free cycles; loads forward from the youngest buffered match.
module data_mem_wbuf #(
   parameter int unsigned DataWidth = 16,
   parameter int unsigned AddrBits  = 8,
   parameter int unsigned BufDepth  = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 MemRead,
   input  logic                 MemWrite,
   input  logic [DataWidth-1:0] MemAddr,
   input  logic [DataWidth-1:0] MemData,
   output logic [DataWidth-1:0] MemOutput,
   output logic                 MemStall,
   output logic                 BufEmpty
);

   localparam int unsigned PtrW     = $clog2(BufDepth);
   localparam int unsigned CntW     = $clog2(BufDepth + 1);
   localparam int unsigned RamWords = 1 << AddrBits;

   logic [DataWidth-1:0] r_ram      [RamWords];
   logic [AddrBits-1:0]  r_buf_addr [BufDepth];
   logic [DataWidth-1:0] r_buf_data [BufDepth];
   logic [PtrW-1:0]      r_head;
   logic [PtrW-1:0]      r_tail;
   logic [CntW-1:0]      r_count;

   logic [AddrBits-1:0]  w_addr;
   logic                 w_full;
   logic                 w_accept;
   logic                 w_drain;
   logic                 w_fwd_hit;
   logic [DataWidth-1:0] w_fwd_data;
   logic                 w_unused_addr;

   // Upper address bits alias onto the same word and are deliberately ignored.
   assign w_addr        = MemAddr[AddrBits-1:0];
   assign w_unused_addr = ^MemAddr[DataWidth-1:AddrBits];

   assign w_full   = (r_count == CntW'(BufDepth));
   assign w_accept = MemWrite & ~w_full;
   assign w_drain  = (r_count != '0) & ~MemRead;

   assign MemStall = MemWrite & w_full;
   assign BufEmpty = (r_count == '0);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_accept) r_tail <= r_tail + PtrW'(1);
         if (w_drain)  r_head <= r_head + PtrW'(1);
         case ({w_accept, w_drain})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage arrays carry no reset: RAM must survive RST, and stale entries are masked by count.
   always_ff @(posedge CLK) begin
      if (w_accept) begin
         r_buf_addr[r_tail] <= w_addr;
         r_buf_data[r_tail] <= MemData;
      end
      if (w_drain) r_ram[r_buf_addr[r_head]] <= r_buf_data[r_head];
   end

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      for (int unsigned i = 0; i < BufDepth; i++) begin
         logic [PtrW-1:0] idx;
         idx = r_head + PtrW'(i);
         if ((CntW'(i) < r_count) && (r_buf_addr[idx] == w_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_buf_data[idx];
         end
      end
   end

   always_comb begin
      MemOutput = '0;
      if (MemRead) MemOutput = w_fwd_hit ? w_fwd_data : r_ram[w_addr];
   end

endmodule

// File: tb/tb_data_mem_wbuf.sv
// Directed vector bench for data_mem_wbuf: one table record per clock cycle,
// plus a hand-written asynchronous mid-cycle reset sequence.
module tb_data_mem_wbuf;

   logic        CLK;
   logic        RST;
   logic        MemRead;
   logic        MemWrite;
   logic [15:0] MemAddr;
   logic [15:0] MemData;
   logic [15:0] MemOutput;
   logic        MemStall;
   logic        BufEmpty;

   int n_tests;
   int n_fail;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] exp_out;
      logic        exp_stall;
      logic        exp_empty;
   } vec_t;

   vec_t vecs[$];

   data_mem_wbuf #(.DataWidth(16), .AddrBits(8), .BufDepth(4)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .MemAddr   (MemAddr),
      .MemData   (MemData),
      .MemOutput (MemOutput),
      .MemStall  (MemStall),
      .BufEmpty  (BufEmpty)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
      end
   endtask

   task automatic add(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [15:0] data, input logic [15:0] exp_out,
                      input logic exp_stall, input logic exp_empty);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.data = data;
      v.exp_out = exp_out; v.exp_stall = exp_stall; v.exp_empty = exp_empty;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data);
      MemRead  = rd;
      MemWrite = wr;
      MemAddr  = addr;
      MemData  = data;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      RST = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);

      // Power-up and store/drain
      add(1, 0, 16'h0005, 16'h0000, 16'h0000, 0, 1);
      add(0, 1, 16'h0003, 16'h1234, 16'h0000, 0, 1);
      add(1, 0, 16'h0003, 16'h0000, 16'h1234, 0, 0);
      add(1, 0, 16'h0003, 16'h0000, 16'h1234, 0, 0);
      add(1, 0, 16'h0003, 16'h0000, 16'h1234, 0, 0);
      add(0, 0, 16'h0003, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 16'h0003, 16'h0000, 16'h1234, 0, 1);
      // Youngest forwarding
      add(1, 1, 16'h0007, 16'h1111, 16'h0000, 0, 1);
      add(1, 1, 16'h0007, 16'h2222, 16'h1111, 0, 0);
      add(1, 0, 16'h0007, 16'h0000, 16'h2222, 0, 0);
      add(0, 0, 16'h0007, 16'h0000, 16'h0000, 0, 0);
      add(0, 0, 16'h0007, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 16'h0007, 16'h0000, 16'h2222, 0, 1);
      // Aliasing
      add(0, 1, 16'h0103, 16'hBEEF, 16'h0000, 0, 1);
      add(1, 0, 16'h0003, 16'h0000, 16'hBEEF, 0, 0);
      add(0, 0, 16'h0003, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 16'h0003, 16'h0000, 16'hBEEF, 0, 1);
      add(1, 0, 16'h0103, 16'h0000, 16'hBEEF, 0, 1);
      // Fill the buffer under continuous loads
      add(1, 1, 16'h0010, 16'h00A0, 16'h0000, 0, 1);
      add(1, 1, 16'h0011, 16'h00A1, 16'h0000, 0, 0);
      add(1, 1, 16'h0012, 16'h00A2, 16'h0000, 0, 0);
      add(1, 1, 16'h0013, 16'h00A3, 16'h0000, 0, 0);
      add(1, 0, 16'h0012, 16'h0000, 16'h00A2, 0, 0);
      // Stalled fifth store while loads continue, then released
      add(1, 1, 16'h0014, 16'h00A4, 16'h0000, 1, 0);
      add(1, 1, 16'h0014, 16'h00A4, 16'h0000, 1, 0);
      add(1, 1, 16'h0014, 16'h00A4, 16'h0000, 1, 0);
      add(0, 1, 16'h0014, 16'h00A4, 16'h0000, 1, 0);
      add(0, 1, 16'h0014, 16'h00A4, 16'h0000, 0, 0);
      add(1, 0, 16'h0014, 16'h0000, 16'h00A4, 0, 0);
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      add(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      add(1, 0, 16'h0010, 16'h0000, 16'h00A0, 0, 1);
      add(1, 0, 16'h0011, 16'h0000, 16'h00A1, 0, 1);
      add(1, 0, 16'h0012, 16'h0000, 16'h00A2, 0, 1);
      add(1, 0, 16'h0013, 16'h0000, 16'h00A3, 0, 1);
      add(1, 0, 16'h0014, 16'h0000, 16'h00A4, 0, 1);

      #12 RST = 1'b1;
      @(posedge CLK); #1;

      // Inputs change 1 after the edge, outputs are sampled 4 later, well before the next edge.
      foreach (vecs[k]) begin
         drive(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].data);
         #4;
         check($sformatf("vec%0d_out", k), MemOutput, vecs[k].exp_out);
         check($sformatf("vec%0d_stall", k), 16'(MemStall), 16'(vecs[k].exp_stall));
         check($sformatf("vec%0d_empty", k), 16'(BufEmpty), 16'(vecs[k].exp_empty));
         @(posedge CLK); #1;
      end

      // Mid-cycle reset discards buffered stores but leaves RAM alone
      drive(1'b1, 1'b1, 16'h0020, 16'h5555);
      @(posedge CLK); #1;
      drive(1'b1, 1'b1, 16'h0021, 16'h6666);
      @(posedge CLK); #1;
      drive(1'b1, 1'b0, 16'h0021, 16'h0000);
      #1;
      check("rst_pre_fwd", MemOutput, 16'h6666);
      check("rst_pre_empty", 16'(BufEmpty), 16'h0000);
      RST = 1'b0;
      #1;
      check("rst_async_empty", 16'(BufEmpty), 16'h0001);
      check("rst_async_out21", MemOutput, 16'h0000);
      #1 RST = 1'b1;
      @(posedge CLK); #1;
      drive(1'b1, 1'b0, 16'h0020, 16'h0000);
      #4;
      check("rst_load20", MemOutput, 16'h0000);
      @(posedge CLK); #1;
      drive(1'b1, 1'b0, 16'h0021, 16'h0000);
      #4;
      check("rst_load21", MemOutput, 16'h0000);
      @(posedge CLK); #1;
      drive(1'b1, 1'b0, 16'h0003, 16'h0000);
      #4;
      check("rst_ram_kept", MemOutput, 16'hBEEF);
      check("rst_empty_after", 16'(BufEmpty), 16'h0001);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      #1;
      check("rd0_out_zero", MemOutput, 16'h0000);
      @(posedge CLK); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_wbuf.md
# data_mem_wbuf

Data-memory unit that sits directly downstream of `Pipelined_Processor` on its `MemRead`/`MemWrite`/`MemAddr`/`MemData`/`MemOutput` port. It replaces the memory model the top-level benches currently drive by hand. It holds a single-port word RAM behind a small store FIFO (write buffer). Stores retire to RAM only in cycles with no load, and loads are served combinationally with forwarding from the youngest matching buffered store.

## Interface
- `DataWidth`, 16, word width; matches the processor datapath.
- `AddrBits`, 8, RAM index width; RAM holds 2^AddrBits words; only `MemAddr[AddrBits-1:0]` is used.
- `BufDepth`, 4, write-buffer entries; must be a power of two, ≥2.
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `MemRead` in 1: load request this cycle.
- `MemWrite` in 1: store request this cycle.
- `MemAddr` in DataWidth: word address, shared by load and store.
- `MemData` in DataWidth: store data.
- `MemOutput` out DataWidth: load data (combinational).
- `MemStall` out 1: store cannot be accepted this cycle; processor holds the store.
- `BufEmpty` out 1: write buffer empty; all accepted stores are in RAM.

## Operation
- State: FIFO of {addr[AddrBits-1:0], data} entries, head/tail pointers (mod BufDepth, wrap naturally), count 0..BufDepth, RAM array.
- Reset (`RST`=0, asynchronous):
  - Pointers and count are cleared; buffered stores are discarded.
  - RAM contents are untouched; RAM is zero at time 0.
- Load: when `MemRead`=1, `MemOutput` = data of the youngest buffer entry whose addr equals `MemAddr[AddrBits-1:0]`; otherwise `RAM[MemAddr[AddrBits-1:0]]`. When `MemRead`=0, `MemOutput` = 0.
- Accept: `MemWrite`=1 and count<BufDepth → enqueue {addr, `MemData`} at the tail on the edge.
- Stall: `MemStall` = `MemWrite` & (count==BufDepth). A stalled store is not enqueued.
- Drain: count>0 and `MemRead`=0 → head entry is written to RAM and popped on the edge. At most one drain per cycle. No drain in any cycle with `MemRead`=1 (single RAM port).
- Accept and drain in the same cycle: count unchanged.
- Load and store in the same cycle, same address:
  - The load returns the pre-store value.
  - The store is enqueued if not full.
  - No drain occurs that cycle.
- Aliasing: addresses differing only above bit AddrBits-1 hit the same word, both for forwarding and RAM.
- `BufEmpty` = (count==0).

## Timing
- Reset values: `MemStall`=0, `BufEmpty`=1, `MemOutput`=0 (with `MemRead`=0).
- Load latency: 0 cycles (combinational from `MemAddr`/`MemRead`/state).
- Store visibility: an accepted store is visible to loads from the next cycle, via forwarding, until it drains.
- RAM update: earliest one edge after accept, delayed by every cycle with `MemRead`=1 and by older entries.
- Full + stalled store with `MemRead`=0:
  - Stall cycle: `MemStall`=1 and the head drains.
  - Next cycle: `MemStall`=0 and the store is accepted.
- Full + stalled store with `MemRead`=1: `MemStall` stays 1 every cycle until a cycle with `MemRead`=0.
- `MemStall` and `BufEmpty` are functions of registered count plus `MemWrite`. They never depend on `MemAddr`/`MemData`.

## Test plan
- Power-up: assert `RST`=0, release, `MemRead`=1 `MemAddr`=0x0005 → `MemOutput`=0x0000, `BufEmpty`=1, `MemStall`=0.
- Store then drain:
  - Store 0x1234 to 0x0003 (`MemRead`=0), then load 0x0003 for 3 cycles → `MemOutput`=0x1234 each cycle, `BufEmpty`=0 throughout.
  - Drop `MemRead` one cycle → `BufEmpty`=1; reload 0x0003 → 0x1234 from RAM.
- Youngest forwarding:
  - With `MemRead`=1, store 0x1111 then 0x2222 to 0x0007 in consecutive cycles; each same-cycle load returns the old value, 0x0000 then 0x1111.
  - Next cycle, load 0x0007 → 0x2222.
  - Drain fully → RAM[7]=0x2222.
- Full/stall:
  - With `MemRead`=1, store 0xA0..0xA3 to 0x10..0x13 → count 4.
  - Fifth store 0xA4 to 0x14, `MemRead` held 1 → `MemStall`=1 for 3 cycles, nothing accepted.
  - Drop `MemRead` → `MemStall`=1 one more cycle, then 0, and 0xA4 is accepted.
  - All five words correct after `BufEmpty`=1.
- Reset mid-operation:
  - Buffer 0x5555→0x0020 and 0x6666→0x0021 (with `MemRead`=1).
  - Pulse `RST`=0 mid-cycle → `BufEmpty`=1 immediately, before the next edge.
  - Loads of 0x0020/0x0021 → 0x0000.
- Aliasing: store 0xBEEF to 0x0103, load 0x0003 → 0xBEEF (forwarded), and again after drain (RAM).
